// File: rtl/scan_pkg.sv
// Shared definitions for the display scan path: mode encodings and a
// one-hot helper sized for the largest supported channel count.
package scan_pkg;

    localparam logic MODE_AUTO    = 1'b0;
    localparam logic MODE_MANUAL  = 1'b1;
    localparam int   MAX_CHANNELS = 16;

    // Callers slice the low 'channels' bits of the result.
    function automatic logic [MAX_CHANNELS-1:0] onehot(input int unsigned index,
                                                       input int unsigned channels);
        logic [MAX_CHANNELS-1:0] result;
        result = '0;
        if ((index < channels) && (index < MAX_CHANNELS)) begin
            result = MAX_CHANNELS'(1) << index;
        end
        return result;
    endfunction

endpackage

// File: rtl/scan_mux_tick_gen.sv
// Free-running prescaler: pulses tick once every DIV cycles of 'run'.
// 'clr' restarts the count and suppresses the tick in that cycle.
module tick_gen #(
    parameter int DIV = 100000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic clr,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] count;
    logic          at_end;

    generate
        if (DIV < 2) begin : g_div_check
            $error("tick_gen: DIV must be at least 2");
        end
    endgenerate

    assign at_end = (count == CW'(DIV - 1));
    assign tick   = run & ~clr & at_end;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (run) begin
            count <= at_end ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/scan_mux.sv
// Time-multiplexed display multiplexer: auto-scans or statically selects one
// of CHANNELS values, with a blank cycle on every digit switch.
module scan_mux
    import scan_pkg::*;
#(
    parameter  int WIDTH    = 4,
    parameter  int CHANNELS = 4,
    parameter  int DIV      = 100000,
    localparam int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel_in,
    input  logic [CHANNELS*WIDTH-1:0] data_in,
    input  logic [CHANNELS-1:0]       blank_mask,
    output logic [WIDTH-1:0]          data_out,
    output logic [SEL_W-1:0]          sel_out,
    output logic [CHANNELS-1:0]       digit_en,
    output logic                      frame_tick
);

    logic [SEL_W-1:0]        idx;
    logic [SEL_W-1:0]        idx_next;
    logic                    guard;
    logic                    mode_q;
    logic                    mode_chg;
    logic                    run;
    logic                    tick;
    logic [MAX_CHANNELS-1:0] oh;

    generate
        if ((CHANNELS < 2) || (CHANNELS > MAX_CHANNELS)) begin : g_ch_check
            $error("scan_mux: CHANNELS must be in 2..16");
        end
    endgenerate

    assign mode_chg = (mode != mode_q);
    assign run      = en && (mode == MODE_AUTO);
    assign oh       = onehot(32'(idx), CHANNELS);

    // A mode change clears the prescaler and masks a coincident tick.
    tick_gen #(.DIV(DIV)) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .run   (run),
        .clr   (mode_chg),
        .tick  (tick)
    );

    always_comb begin
        idx_next = idx;
        if (en) begin
            if (mode == MODE_MANUAL) begin
                if (int'(sel_in) < CHANNELS) begin
                    idx_next = sel_in;
                end
            end else if (tick) begin
                idx_next = (idx == SEL_W'(CHANNELS - 1)) ? '0 : idx + 1'b1;
            end
        end
    end

    // guard delays the new one-hot by a cycle so two digits never overlap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q     <= MODE_AUTO;
            idx        <= '0;
            guard      <= 1'b0;
            data_out   <= '0;
            sel_out    <= '0;
            digit_en   <= '0;
            frame_tick <= 1'b0;
        end else begin
            mode_q     <= mode;
            idx        <= idx_next;
            guard      <= (idx_next != idx);
            data_out   <= data_in[int'(idx)*WIDTH +: WIDTH];
            sel_out    <= idx;
            digit_en   <= (!en || guard || blank_mask[idx]) ? '0 : oh[CHANNELS-1:0];
            frame_tick <= tick && (idx == SEL_W'(CHANNELS - 1));
        end
    end

endmodule

// File: tb/tb_scan_mux.sv
// Self-checking bench for scan_mux (3 channels, DIV=4): a cycle model feeds a
// scoreboard queue, plus directed checks on the scan timing.
module tb_scan_mux;

    localparam int WIDTH    = 4;
    localparam int CHANNELS = 3;
    localparam int DIV      = 4;
    localparam int SEL_W    = 2;

    typedef struct packed {
        logic [WIDTH-1:0]    d;
        logic [SEL_W-1:0]    s;
        logic [CHANNELS-1:0] de;
        logic                ft;
    } exp_t;

    logic                      clk;
    logic                      rst_n;
    logic                      en;
    logic                      mode;
    logic [SEL_W-1:0]          sel_in;
    logic [CHANNELS*WIDTH-1:0] data_in;
    logic [CHANNELS-1:0]       blank_mask;
    logic [WIDTH-1:0]          data_out;
    logic [SEL_W-1:0]          sel_out;
    logic [CHANNELS-1:0]       digit_en;
    logic                      frame_tick;

    exp_t sb[$];
    int   checks;
    int   errors;
    int   m_idx;
    int   m_cnt;
    logic m_guard;
    logic m_prev;
    int   ft_count;

    scan_mux #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .DIV(DIV)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .mode       (mode),
        .sel_in     (sel_in),
        .data_in    (data_in),
        .blank_mask (blank_mask),
        .data_out   (data_out),
        .sel_out    (sel_out),
        .digit_en   (digit_en),
        .frame_tick (frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic modelReset();
        m_idx   = 0;
        m_cnt   = 0;
        m_guard = 1'b0;
        m_prev  = 1'b0;
        sb.delete();
    endtask

    // Expected outputs after the coming edge depend on the state before it.
    task automatic modelStep(input logic e, input logic md, input logic [SEL_W-1:0] s,
                             input logic [CHANNELS-1:0] b, input logic [CHANNELS*WIDTH-1:0] d);
        exp_t x;
        int   nidx;
        int   ncnt;
        logic chg;
        logic tk;
        chg = (md != m_prev);
        tk  = e && !md && !chg && (m_cnt == DIV - 1);
        if (chg) ncnt = 0;
        else if (e && !md) ncnt = (m_cnt == DIV - 1) ? 0 : m_cnt + 1;
        else ncnt = m_cnt;
        nidx = m_idx;
        if (e) begin
            if (md) begin
                if (int'(s) < CHANNELS) nidx = int'(s);
            end else if (tk) begin
                nidx = (m_idx == CHANNELS - 1) ? 0 : m_idx + 1;
            end
        end
        x.d  = d[m_idx*WIDTH +: WIDTH];
        x.s  = SEL_W'(m_idx);
        x.de = (!e || m_guard || b[m_idx]) ? '0 : CHANNELS'(1 << m_idx);
        x.ft = tk && (m_idx == CHANNELS - 1);
        sb.push_back(x);
        m_guard = (nidx != m_idx);
        m_idx   = nidx;
        m_cnt   = ncnt;
        m_prev  = md;
    endtask

    task automatic applyStimulus(input logic e, input logic md, input logic [SEL_W-1:0] s,
                                 input logic [CHANNELS-1:0] b, input logic [CHANNELS*WIDTH-1:0] d);
        exp_t x;
        en         = e;
        mode       = md;
        sel_in     = s;
        blank_mask = b;
        data_in    = d;
        modelStep(e, md, s, b, d);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checkOutput("sb_underflow", 32'd0, 32'd1);
        end else begin
            x = sb.pop_front();
            checkOutput("data_out", 32'(data_out), 32'(x.d));
            checkOutput("sel_out", 32'(sel_out), 32'(x.s));
            checkOutput("digit_en", 32'(digit_en), 32'(x.de));
            checkOutput("frame_tick", 32'(frame_tick), 32'(x.ft));
        end
    endtask

    // Asserts reset between edges so the clear must be asynchronous.
    task automatic doReset();
        en         = 1'b1;
        mode       = 1'b0;
        sel_in     = '0;
        blank_mask = '0;
        rst_n      = 1'b0;
        #1;
        checkOutput("rst_data_out", 32'(data_out), 32'd0);
        checkOutput("rst_sel_out", 32'(sel_out), 32'd0);
        checkOutput("rst_digit_en", 32'(digit_en), 32'd0);
        checkOutput("rst_frame_tick", 32'(frame_tick), 32'd0);
        modelReset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        ft_count = 0;
        data_in  = 12'h952;
        modelReset();
        #2;
        doReset();

        // Reset in the middle of a scan, after idx has reached 2.
        for (int k = 1; k <= 10; k++) applyStimulus(1'b1, 1'b0, 2'd0, 3'b000, 12'h952);
        checkOutput("pre_rst_sel", 32'(sel_out), 32'd2);
        doReset();

        // Auto scan from reset: advances every 4 edges, wraps with frame_tick.
        for (int k = 1; k <= 24; k++) begin
            applyStimulus(1'b1, 1'b0, 2'd0, 3'b000, 12'h952);
            ft_count += int'(frame_tick);
            if (k == 4) begin
                checkOutput("scan_k4_sel", 32'(sel_out), 32'd0);
                checkOutput("scan_k4_den", 32'(digit_en), 32'b001);
            end
            if (k == 5) begin
                checkOutput("scan_k5_sel", 32'(sel_out), 32'd1);
                checkOutput("scan_k5_den", 32'(digit_en), 32'b000);
            end
            if (k == 6) begin
                checkOutput("scan_k6_den", 32'(digit_en), 32'b010);
                checkOutput("scan_k6_data", 32'(data_out), 32'h5);
            end
            if (k == 10) checkOutput("scan_k10_data", 32'(data_out), 32'h9);
            if (k == 12) checkOutput("scan_k12_ft", 32'(frame_tick), 32'd1);
            if (k == 13) checkOutput("scan_k13_sel", 32'(sel_out), 32'd0);
        end
        checkOutput("frame_count", 32'(ft_count), 32'd2);

        // Manual select, then an out-of-range select that must be ignored.
        for (int k = 1; k <= 3; k++) applyStimulus(1'b1, 1'b1, 2'd1, 3'b000, 12'h952);
        checkOutput("man_sel", 32'(sel_out), 32'd1);
        checkOutput("man_data", 32'(data_out), 32'h5);
        checkOutput("man_den", 32'(digit_en), 32'b010);
        for (int k = 1; k <= 3; k++) begin
            applyStimulus(1'b1, 1'b1, 2'd3, 3'b000, 12'h952);
            checkOutput("oor_sel", 32'(sel_out), 32'd1);
            checkOutput("oor_den", 32'(digit_en), 32'b010);
        end

        // Blanked channel 1 keeps data/sel but never lights.
        doReset();
        for (int k = 1; k <= 12; k++) begin
            applyStimulus(1'b1, 1'b0, 2'd0, 3'b010, 12'h952);
            if (k >= 5 && k <= 8) begin
                checkOutput("blank_den", 32'(digit_en), 32'b000);
                checkOutput("blank_sel", 32'(sel_out), 32'd1);
                checkOutput("blank_data", 32'(data_out), 32'h5);
            end
        end

        // Pause at prescaler count 2; the count resumes where it stopped.
        doReset();
        applyStimulus(1'b1, 1'b0, 2'd0, 3'b000, 12'h952);
        applyStimulus(1'b1, 1'b0, 2'd0, 3'b000, 12'h952);
        applyStimulus(1'b0, 1'b0, 2'd0, 3'b000, 12'h952);
        checkOutput("pause_den", 32'(digit_en), 32'b000);
        applyStimulus(1'b0, 1'b0, 2'd0, 3'b000, 12'h952);
        applyStimulus(1'b0, 1'b0, 2'd0, 3'b000, 12'h952);
        checkOutput("pause_sel", 32'(sel_out), 32'd0);
        applyStimulus(1'b1, 1'b0, 2'd0, 3'b000, 12'h952);
        applyStimulus(1'b1, 1'b0, 2'd0, 3'b000, 12'h952);
        checkOutput("resume_sel_b", 32'(sel_out), 32'd0);
        applyStimulus(1'b1, 1'b0, 2'd0, 3'b000, 12'h952);
        checkOutput("resume_sel_c", 32'(sel_out), 32'd1);

        // Mode change coinciding with a tick: manual select wins.
        doReset();
        for (int k = 1; k <= 3; k++) applyStimulus(1'b1, 1'b0, 2'd0, 3'b000, 12'h952);
        applyStimulus(1'b1, 1'b1, 2'd2, 3'b000, 12'h952);
        applyStimulus(1'b1, 1'b1, 2'd2, 3'b000, 12'h952);
        checkOutput("coinc_sel", 32'(sel_out), 32'd2);
        for (int k = 1; k <= 6; k++) applyStimulus(1'b1, 1'b0, 2'd0, 3'b000, 12'h952);

        // Mixed traffic checked against the model.
        for (int k = 1; k <= 60; k++) begin
            applyStimulus(($urandom_range(0, 7) != 0), ($urandom_range(0, 9) == 0),
                          SEL_W'($urandom_range(0, 3)), CHANNELS'($urandom_range(0, 7)),
                          (CHANNELS*WIDTH)'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/scan_mux.md
Name: scan_mux

Overview:
- Parametrised, time-multiplexed N-channel registered multiplexer for the vending-machine display path.
- Auto mode: scans CHANNELS packed W-bit values (price, credit and change digits) onto one shared output bus at a prescaled refresh rate. Drives a one-hot digit enable with an anti-ghosting blank cycle.
- Manual mode: a static selected channel replaces the bare 2:1 combinational selection used so far.

Parameters:
- WIDTH, 4, bit width of each channel and of data_out.
- CHANNELS, 4, number of input channels; legal range 2..16; need not be a power of 2.
- SEL_W, $clog2(CHANNELS), width of index/select buses (derived, not overridden).
- DIV, 100000, clock cycles per scan step; DIV >= 2 is required (elaboration check).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  1 = block active; 0 = freeze index/prescaler, blank outputs.
- mode  input  1  0 = auto-scan, 1 = manual select.
- sel_in  input  SEL_W  manual channel select.
- data_in  input  CHANNELS*WIDTH  packed channels; channel k = data_in[k*WIDTH +: WIDTH].
- blank_mask  input  CHANNELS  1 = channel k never lights its digit enable.
- data_out  output  WIDTH  registered selected channel data.
- sel_out  output  SEL_W  registered current channel index.
- digit_en  output  CHANNELS  registered one-hot enable, active-high.
- frame_tick  output  1  one-cycle pulse when auto scan wraps to channel 0.

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low. Assertion clears all state immediately, regardless of the current step or mode.
- Reset values: idx=0, prescaler=0, guard=0, data_out=0, sel_out=0, digit_en=0, frame_tick=0.
- Prescaler: counts 0..DIV-1 while en=1 and mode=0. tick = (count==DIV-1); count returns to 0 on tick.
  - Prescaler clears to 0 on any mode change.
  - Prescaler holds while en=0.
- Auto index: on tick, idx <= (idx==CHANNELS-1) ? 0 : idx+1. On a wrap, frame_tick=1 for the next cycle only.
- Manual index: idx <= sel_in each cycle when en=1.
  - If sel_in >= CHANNELS, idx holds its previous value (non-power-of-2 CHANNELS).
  - frame_tick stays 0 in manual mode.
- Mode switch: manual->auto continues scanning from the current idx. auto->manual takes sel_in on the next edge.
- Guard: guard <= 1 on any edge where idx changes value, else 0.
- Output latency: data_out <= data_in[idx] and sel_out <= idx every cycle, so outputs lag idx by 1 cycle. A data_in change on a held idx reaches data_out 1 cycle later.
- digit_en <= 0 when any of the following holds: en=0, guard=1, or blank_mask[idx]=1. Otherwise digit_en <= onehot(idx).
- Result after an index change: sel_out/data_out update first, digit_en is 0 for exactly that cycle, and the new one-hot appears 1 cycle later (blank-before-switch).
- en deassertion: digit_en=0 on the next edge. data_out/sel_out keep tracking the frozen idx. On re-enable, the prescaler resumes from its held count.
- Simultaneous events:
  - Mode change and tick in the same cycle: the mode change wins, and no auto advance occurs.
  - Manual sel_in equal to idx: no guard cycle.

Decomposition:
- Shared package (scan_pkg): MODE_AUTO=1'b0, MODE_MANUAL=1'b1, and a onehot function parametrised by CHANNELS.
- One natural sub-module: tick_gen.
  - Parameter: DIV.
  - Inputs: clk, rst_n, run, clr.
  - Output: tick.
  - Reused later for coin-debounce timing.
- Index/guard/output registers stay in scan_mux.

Test Plan:
1. Reset: CHANNELS=3, DIV=4; assert rst_n=0 mid-scan with idx=2. Required: all outputs 0 immediately; after release, idx=0 and first advance after 4 cycles.
2. Auto scan, CHANNELS=3, DIV=4, data_in={4'h9,4'h5,4'h2}.
   - sel_out steps 0,1,2,0 every 4 cycles.
   - data_out steps 2,5,9.
   - digit_en goes 001 -> 000 (1 cycle) -> 010.
   - frame_tick pulses once per 12 cycles, on the 2->0 wrap.
3. Manual mode, CHANNELS=3: sel_in=1 -> sel_out=1, data_out=4'h5, digit_en=010 after guard. sel_in=3 (out of range) -> sel_out stays 1, no guard cycle.
4. Blanking: blank_mask=3'b010 in auto scan. Required: digit_en=000 throughout channel-1 dwell; data_out still 4'h5 and sel_out still 1.
5. en=0 mid-dwell at prescaler count 2. Required: digit_en=000 next cycle, idx frozen. en=1 -> advance occurs 2 cycles later (count resumes at 2).
6. Mode change at the same cycle as tick. Required: no auto advance, prescaler=0, manual sel_in applied on that edge.
